// File: rtl/rom_arbiter_pkg.sv
// Shared widths, master indices and access-size encodings for the ROM arbiter slice.
package rom_arbiter_pkg;

    localparam int unsigned ROM_VA_WIDTH  = 16;
    localparam int unsigned BUS_WIDTH     = 32;
    localparam int unsigned BUS_ACC_WIDTH = 2;

    localparam logic ROM_ARB_M0 = 1'b0;
    localparam logic ROM_ARB_M1 = 1'b1;

    typedef enum logic [BUS_ACC_WIDTH-1:0] {
        AccByte = 2'd0,
        AccHalf = 2'd1,
        AccWord = 2'd2
    } bus_acc_e;

    // Round-robin: hand the contended grant to whoever did not get the last one.
    function automatic logic rr_pick(input logic last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/rom_arb_slot.sv
// One-entry holding register for a request that lost arbitration.
module rom_arb_slot
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned AW = ROM_VA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     capture,
    input  logic                     clear,
    input  logic [AW-1:0]            in_addr,
    input  logic                     in_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] in_acc,
    input  logic [BUS_WIDTH-1:0]     in_wdata,
    output logic                     valid,
    output logic [AW-1:0]            addr,
    output logic                     w_rb,
    output logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     wdata
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            addr  <= '0;
            w_rb  <= 1'b0;
            acc   <= '0;
            wdata <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            addr  <= in_addr;
            w_rb  <= in_w_rb;
            acc   <= in_acc;
            wdata <= in_wdata;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-master arbiter in front of the ROM controller; losers wait one cycle in a pending slot.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned AW   = ROM_VA_WIDTH,
    parameter bit          PRIO = 1'b0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [AW-1:0]            m0_addr,
    input  logic                     m0_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] m0_acc,
    input  logic [BUS_WIDTH-1:0]     m0_wdata,
    input  logic                     m0_req,
    output logic                     m0_resp,
    output logic [BUS_WIDTH-1:0]     m0_rdata,
    output logic                     m0_fault,
    input  logic [AW-1:0]            m1_addr,
    input  logic                     m1_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] m1_acc,
    input  logic [BUS_WIDTH-1:0]     m1_wdata,
    input  logic                     m1_req,
    output logic                     m1_resp,
    output logic [BUS_WIDTH-1:0]     m1_rdata,
    output logic                     m1_fault,
    output logic [AW-1:0]            s_addr,
    output logic                     s_w_rb,
    output logic [BUS_ACC_WIDTH-1:0] s_acc,
    output logic [BUS_WIDTH-1:0]     s_wdata,
    output logic                     s_req,
    input  logic [BUS_WIDTH-1:0]     s_rdata,
    input  logic                     s_resp,
    input  logic                     s_fault
);

    logic [1:0]               pend_v;
    logic [AW-1:0]            p0_addr, p1_addr;
    logic                     p0_w_rb, p1_w_rb;
    logic [BUS_ACC_WIDTH-1:0] p0_acc, p1_acc;
    logic [BUS_WIDTH-1:0]     p0_wdata, p1_wdata;

    logic       cand0, cand1, live0, live1, grant;
    logic       cap0, cap1, clr0, clr1;
    logic       last_grant, owner_q;

    // A live req is ignored while that master already has an entry pending.
    always_comb begin
        live0 = m0_req & ~pend_v[0];
        live1 = m1_req & ~pend_v[1];
        cand0 = pend_v[0] | m0_req;
        cand1 = pend_v[1] | m1_req;
        grant = ROM_ARB_M0;
        if (cand0 && cand1) begin
            grant = PRIO ? ROM_ARB_M0 : rr_pick(last_grant);
        end else if (cand1) begin
            grant = ROM_ARB_M1;
        end
        s_req = cand0 | cand1;
        cap0  = cand0 & cand1 & (grant == ROM_ARB_M1) & live0;
        cap1  = cand0 & cand1 & (grant == ROM_ARB_M0) & live1;
        clr0  = s_req & (grant == ROM_ARB_M0) & pend_v[0];
        clr1  = s_req & (grant == ROM_ARB_M1) & pend_v[1];
    end

    always_comb begin
        if (grant == ROM_ARB_M1) begin
            s_addr  = pend_v[1] ? p1_addr  : m1_addr;
            s_w_rb  = pend_v[1] ? p1_w_rb  : m1_w_rb;
            s_acc   = pend_v[1] ? p1_acc   : m1_acc;
            s_wdata = pend_v[1] ? p1_wdata : m1_wdata;
        end else begin
            s_addr  = pend_v[0] ? p0_addr  : m0_addr;
            s_w_rb  = pend_v[0] ? p0_w_rb  : m0_w_rb;
            s_acc   = pend_v[0] ? p0_acc   : m0_acc;
            s_wdata = pend_v[0] ? p0_wdata : m0_wdata;
        end
    end

    rom_arb_slot #(.AW(AW)) u_slot0 (
        .clk      (clk),
        .rstn     (rstn),
        .capture  (cap0),
        .clear    (clr0),
        .in_addr  (m0_addr),
        .in_w_rb  (m0_w_rb),
        .in_acc   (m0_acc),
        .in_wdata (m0_wdata),
        .valid    (pend_v[0]),
        .addr     (p0_addr),
        .w_rb     (p0_w_rb),
        .acc      (p0_acc),
        .wdata    (p0_wdata)
    );

    rom_arb_slot #(.AW(AW)) u_slot1 (
        .clk      (clk),
        .rstn     (rstn),
        .capture  (cap1),
        .clear    (clr1),
        .in_addr  (m1_addr),
        .in_w_rb  (m1_w_rb),
        .in_acc   (m1_acc),
        .in_wdata (m1_wdata),
        .valid    (pend_v[1]),
        .addr     (p1_addr),
        .w_rb     (p1_w_rb),
        .acc      (p1_acc),
        .wdata    (p1_wdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= ROM_ARB_M1;
            owner_q    <= ROM_ARB_M0;
        end else if (s_req) begin
            last_grant <= grant;
            owner_q    <= grant;
        end
    end

    assign m0_fault = s_fault & s_req & (grant == ROM_ARB_M0);
    assign m1_fault = s_fault & s_req & (grant == ROM_ARB_M1);
    assign m0_resp  = s_resp & (owner_q == ROM_ARB_M0);
    assign m1_resp  = s_resp & (owner_q == ROM_ARB_M1);
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

`ifndef SYNTHESIS
    a_m0_no_req_while_pending: assert property (@(posedge clk) disable iff (!rstn)
        !(m0_req && pend_v[0]));
    a_m1_no_req_while_pending: assert property (@(posedge clk) disable iff (!rstn)
        !(m1_req && pend_v[1]));
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a small behavioural ROM controller as the slave.
module tb_rom_arbiter;
    import rom_arbiter_pkg::*;

    localparam int unsigned AW = ROM_VA_WIDTH;

    logic                     clk, rstn;
    logic [AW-1:0]            m0_addr, m1_addr, s_addr;
    logic                     m0_w_rb, m1_w_rb, s_w_rb;
    logic [BUS_ACC_WIDTH-1:0] m0_acc, m1_acc, s_acc;
    logic [BUS_WIDTH-1:0]     m0_wdata, m1_wdata, s_wdata;
    logic                     m0_req, m1_req, s_req;
    logic                     m0_resp, m1_resp, m0_fault, m1_fault;
    logic [BUS_WIDTH-1:0]     m0_rdata, m1_rdata;
    logic [BUS_WIDTH-1:0]     sl_rdata;
    logic                     sl_resp, sl_fault;
    logic [31:0]              rom [8];

    int n_tests = 0;
    int n_fail  = 0;

    rom_arbiter #(.AW(AW), .PRIO(1'b0)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .m0_addr  (m0_addr),
        .m0_w_rb  (m0_w_rb),
        .m0_acc   (m0_acc),
        .m0_wdata (m0_wdata),
        .m0_req   (m0_req),
        .m0_resp  (m0_resp),
        .m0_rdata (m0_rdata),
        .m0_fault (m0_fault),
        .m1_addr  (m1_addr),
        .m1_w_rb  (m1_w_rb),
        .m1_acc   (m1_acc),
        .m1_wdata (m1_wdata),
        .m1_req   (m1_req),
        .m1_resp  (m1_resp),
        .m1_rdata (m1_rdata),
        .m1_fault (m1_fault),
        .s_addr   (s_addr),
        .s_w_rb   (s_w_rb),
        .s_acc    (s_acc),
        .s_wdata  (s_wdata),
        .s_req    (s_req),
        .s_rdata  (sl_rdata),
        .s_resp   (sl_resp),
        .s_fault  (sl_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_read(input logic [AW-1:0] a, input logic [1:0] acc);
        logic [31:0] w;
        w = rom[a[4:2]];
        case (acc)
            2'd0:    return {24'h0, w[8*a[1:0] +: 8]};
            2'd1:    return {16'h0, w[16*a[1] +: 16]};
            default: return w;
        endcase
    endfunction

    // ROM controller model: writes and misaligned accesses fault in the issue cycle.
    assign sl_fault = s_req && (s_w_rb || (s_acc == 2'd1 && s_addr[0]) ||
                                (s_acc == 2'd2 && s_addr[1:0] != 2'b00));

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sl_resp  <= 1'b0;
            sl_rdata <= '0;
        end else begin
            sl_resp  <= s_req && !sl_fault;
            sl_rdata <= rom_read(s_addr, s_acc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_addr = '0; m0_w_rb = 1'b0; m0_acc = 2'd2; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_w_rb = 1'b0; m1_acc = 2'd2; m1_wdata = '0;
    endtask

    task automatic drive_m0(input logic [AW-1:0] a, input logic wrb, input logic [1:0] acc);
        m0_req = 1'b1; m0_addr = a; m0_w_rb = wrb; m0_acc = acc; m0_wdata = 32'hFEED0000;
    endtask

    task automatic drive_m1(input logic [AW-1:0] a, input logic wrb, input logic [1:0] acc);
        m1_req = 1'b1; m1_addr = a; m1_w_rb = wrb; m1_acc = acc; m1_wdata = 32'hFEED0001;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        @(posedge clk);
        #3 rstn = 1'b1;
    endtask

    initial begin
        rom[0] = 32'hDEADBEEF; rom[1] = 32'hCAFEF00D; rom[2] = 32'h0BADF00D;
        rom[3] = 32'h55667788; rom[4] = 32'h11223344; rom[5] = 32'hA5A5A5A5;
        rom[6] = 32'h12345678; rom[7] = 32'h87654321;
        rstn = 1'b0;
        idle();
        #12 rstn = 1'b1;
        #1;
        check("rst_s_req", 32'(s_req), 32'd0);
        check("rst_m0_resp", 32'(m0_resp), 32'd0);
        check("rst_m1_resp", 32'(m1_resp), 32'd0);
        check("rst_m0_fault", 32'(m0_fault), 32'd0);
        check("rst_m1_fault", 32'(m1_fault), 32'd0);

        // Uncontended m0 read
        tick(); drive_m0(16'h010, 1'b0, 2'd2); #1;
        check("unc_s_req", 32'(s_req), 32'd1);
        check("unc_s_addr", 32'(s_addr), 32'h010);
        check("unc_m0_fault", 32'(m0_fault), 32'd0);
        tick(); idle(); #1;
        check("unc_m0_resp", 32'(m0_resp), 32'd1);
        check("unc_m0_rdata", m0_rdata, 32'h11223344);
        check("unc_m1_resp", 32'(m1_resp), 32'd0);
        tick(); #1;
        check("unc_m0_resp_once", 32'(m0_resp), 32'd0);

        // Contention straight after reset: m0 wins, m1 follows a cycle later
        do_reset();
        tick(); drive_m0(16'h000, 1'b0, 2'd2); drive_m1(16'h004, 1'b0, 2'd2); #1;
        check("con_c0_s_addr", 32'(s_addr), 32'h000);
        tick(); idle(); #1;
        check("con_c1_s_req", 32'(s_req), 32'd1);
        check("con_c1_s_addr", 32'(s_addr), 32'h004);
        check("con_c1_m0_resp", 32'(m0_resp), 32'd1);
        check("con_c1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("con_c1_m1_resp", 32'(m1_resp), 32'd0);
        tick(); #1;
        check("con_c2_m1_resp", 32'(m1_resp), 32'd1);
        check("con_c2_m1_rdata", m1_rdata, 32'hCAFEF00D);
        check("con_c2_m0_resp", 32'(m0_resp), 32'd0);
        check("con_c2_s_req", 32'(s_req), 32'd0);

        // Saturated traffic: grants go m0, then m1, m0, m1, m0
        tick(); drive_m0(16'h008, 1'b0, 2'd2); drive_m1(16'h00C, 1'b0, 2'd2); #1;
        check("rr_c0_s_addr", 32'(s_addr), 32'h008);
        tick(); idle(); drive_m0(16'h010, 1'b0, 2'd2); #1;
        check("rr_c1_s_addr", 32'(s_addr), 32'h00C);
        check("rr_c1_m0_resp", 32'(m0_resp), 32'd1);
        check("rr_c1_m0_rdata", m0_rdata, 32'h0BADF00D);
        tick(); idle(); drive_m1(16'h014, 1'b0, 2'd2); #1;
        check("rr_c2_s_addr", 32'(s_addr), 32'h010);
        check("rr_c2_m1_resp", 32'(m1_resp), 32'd1);
        check("rr_c2_m1_rdata", m1_rdata, 32'h55667788);
        tick(); idle(); drive_m0(16'h018, 1'b0, 2'd2); #1;
        check("rr_c3_s_addr", 32'(s_addr), 32'h014);
        check("rr_c3_m0_resp", 32'(m0_resp), 32'd1);
        check("rr_c3_m0_rdata", m0_rdata, 32'h11223344);
        tick(); idle(); #1;
        check("rr_c4_s_addr", 32'(s_addr), 32'h018);
        check("rr_c4_m1_resp", 32'(m1_resp), 32'd1);
        check("rr_c4_m1_rdata", m1_rdata, 32'hA5A5A5A5);
        tick(); #1;
        check("rr_c5_m0_resp", 32'(m0_resp), 32'd1);
        check("rr_c5_m0_rdata", m0_rdata, 32'h12345678);
        check("rr_c5_s_req", 32'(s_req), 32'd0);

        // m1 wins, buffered m0 write faults when it leaves the slot
        tick(); drive_m0(16'h000, 1'b1, 2'd2); drive_m1(16'h01C, 1'b0, 2'd2); #1;
        check("bf_c0_s_addr", 32'(s_addr), 32'h01C);
        check("bf_c0_m0_fault", 32'(m0_fault), 32'd0);
        tick(); idle(); #1;
        check("bf_c1_s_req", 32'(s_req), 32'd1);
        check("bf_c1_s_addr", 32'(s_addr), 32'h000);
        check("bf_c1_s_w_rb", 32'(s_w_rb), 32'd1);
        check("bf_c1_s_wdata", s_wdata, 32'hFEED0000);
        check("bf_c1_m0_fault", 32'(m0_fault), 32'd1);
        check("bf_c1_m1_resp", 32'(m1_resp), 32'd1);
        check("bf_c1_m1_rdata", m1_rdata, 32'h87654321);
        tick(); #1;
        check("bf_c2_m0_resp", 32'(m0_resp), 32'd0);
        check("bf_c2_m0_fault", 32'(m0_fault), 32'd0);

        // Misaligned m0 half-word faults; m1 byte read follows
        tick(); drive_m0(16'h001, 1'b0, 2'd1); #1;
        check("al_c0_m0_fault", 32'(m0_fault), 32'd1);
        check("al_c0_m1_fault", 32'(m1_fault), 32'd0);
        tick(); idle(); drive_m1(16'h008, 1'b0, 2'd0); #1;
        check("al_c1_m1_fault", 32'(m1_fault), 32'd0);
        check("al_c1_m0_resp", 32'(m0_resp), 32'd0);
        check("al_c1_m0_fault", 32'(m0_fault), 32'd0);
        tick(); idle(); #1;
        check("al_c2_m1_resp", 32'(m1_resp), 32'd1);
        check("al_c2_m1_rdata", m1_rdata, 32'h0000000D);
        check("al_c2_m0_resp", 32'(m0_resp), 32'd0);

        // Reset while m1 is pending
        tick(); drive_m0(16'h000, 1'b0, 2'd2); drive_m1(16'h004, 1'b0, 2'd2); #1;
        check("rm_c0_s_addr", 32'(s_addr), 32'h000);
        rstn = 1'b0;
        idle();
        #1;
        check("rm_in_rst_s_req", 32'(s_req), 32'd0);
        check("rm_in_rst_m1_fault", 32'(m1_fault), 32'd0);
        @(posedge clk);
        #3 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rm_post_s_req", 32'(s_req), 32'd0);
            check("rm_post_resp", 32'({m0_resp, m1_resp}), 32'd0);
            check("rm_post_fault", 32'({m0_fault, m1_fault}), 32'd0);
        end
        tick(); drive_m0(16'h010, 1'b0, 2'd2); drive_m1(16'h014, 1'b0, 2'd2); #1;
        check("rm_con_s_addr", 32'(s_addr), 32'h010);
        tick(); idle(); #1;
        check("rm_con_pend_s_addr", 32'(s_addr), 32'h014);
        check("rm_con_m0_resp", 32'(m0_resp), 32'd1);
        check("rm_con_m0_rdata", m0_rdata, 32'h11223344);
        tick(); #1;
        check("rm_con_m1_resp", 32'(m1_resp), 32'd1);
        check("rm_con_m1_rdata", m1_rdata, 32'hA5A5A5A5);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single ROM controller slave port between two bus masters: m0 = instruction fetch, m1 = data load.
- Arbitrates same-cycle requests and buffers the losing request in a one-entry pending slot.
- Routes resp, rdata and fault back to the issuing master.
- Sits between the core bus ports and the ROM controller. The slave has no backpressure: it accepts one request per cycle and answers one cycle later.

Parameters:
- AW, `ROM_VA_WIDTH: address width of all addr ports.
- PRIO, 0: 0 = round-robin arbitration; 1 = fixed priority, m0 always wins.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- m0_addr / m1_addr  in  AW  master request address
- m0_w_rb / m1_w_rb  in  1  1 = write, 0 = read (passed through; the ROM faults writes)
- m0_acc / m1_acc  in  `BUS_ACC_WIDTH  access size
- m0_wdata / m1_wdata  in  `BUS_WIDTH  write data (passed through)
- m0_req / m1_req  in  1  single-cycle request strobe
- m0_resp / m1_resp  out  1  response strobe
- m0_rdata / m1_rdata  out  `BUS_WIDTH  read data, valid with resp
- m0_fault / m1_fault  out  1  request rejected
- s_addr, s_w_rb, s_acc, s_wdata, s_req  out  (same widths)  slave request
- s_rdata  in  `BUS_WIDTH  slave read data
- s_resp  in  1  slave response, one cycle after an accepted s_req
- s_fault  in  1  slave combinational fault, same cycle as s_req

Behaviour:
- Reset (asynchronous):
  - pend_v[1:0] = 0; owner_q = 0.
  - last_grant = 1, so m0 wins the first contention.
  - All mN_resp and mN_fault = 0. s_req = 0 while no candidate exists.
- Candidate per master i: the pending slot if pend_v[i] is set, otherwise the live mi_req with its fields.
- Exactly one candidate: grant it combinationally; s_* = that candidate's fields; s_req = 1.
- Two candidates:
  - PRIO=0: grant the master not equal to last_grant.
  - PRIO=1: grant m0.
  - The loser, if live, is captured into its pending slot (addr/w_rb/acc/wdata, pend_v <= 1). A loser already pending stays pending.
- Grant bookkeeping: on any grant, last_grant <= granted index. A granted pending slot clears pend_v the same edge.
- Fault: mi_fault = s_fault & (grant == i), combinational in the issue cycle. For a buffered request this is the cycle it leaves the slot, not the original req cycle. A faulted request produces no resp.
- Response:
  - owner_q <= grant index every cycle s_req is high.
  - mi_resp = s_resp & (owner_q == i).
  - mi_rdata = s_rdata broadcast to both masters; valid only with mi_resp.
- Latency:
  - Uncontended request: resp 1 cycle after req, identical to a direct connection.
  - Contention loser: resp 2 cycles after req.
  - Round-robin bounds the wait to one extra cycle. With PRIO=1, m1 can starve under back-to-back m0 traffic; this is documented, not guarded.
- Throughput: one slave issue per cycle, back-to-back, no bubbles.
- Master rule: a master issues no new req until its resp or fault.
  - Violation (mi_req while pend_v[i]): the live req is ignored, the pending entry is kept, and a simulation-only assertion fires.
- Reset mid-operation: pending entries are dropped silently. A slave resp arriving after reset release with no owner is ignored; owner_q is reset and the slave's resp is also reset.
- Independent of addr alignment; alignment faults are generated by the ROM and forwarded unchanged.

Decomposition:
- femto.vh gains `ROM_ARB_M0 (0) and `ROM_ARB_M1 (1) index macros. Bus width and acc encodings already live there.
- One sub-module, rom_arb_slot: a one-entry request holding register with capture/release/valid. Instantiated twice.
- Arbitration and response routing stay in rom_arbiter.

Test Plan:
- Uncontended: m0 read addr 0x010 acc 4B; ROM word 0x11223344 → m0_resp next cycle, m0_rdata = 0x11223344, m1_resp stays 0.
- Contention after reset, PRIO=0: m0 0x000 and m1 0x004 in the same cycle → s_addr 0x000 in cycle 0, then 0x004 in cycle 1. m0_resp at +1, m1_resp at +2, each with its own word.
- Repeated contention, PRIO=0, four rounds → grants alternate m1, m0, m1, m0 after the first m0 win. No request waits more than 1 extra cycle.
- Fault on a buffered request: m1 wins, m0 loses with a write (w_rb=1) → m0_fault = 1 in the following cycle with s_req high, no m0_resp.
- Interleaving with an alignment fault: m0 0x001 acc 2B alone → m0_fault same cycle, no resp. Next cycle m1 0x008 acc 1B → m1_resp next cycle with byte 0 of that word.
- Reset mid-operation: assert rstn low while m1 is pending → pend_v clears immediately, no resp or fault afterwards. The first contention after release grants m0.
